// File: rtl/seq_recorder_pkg.sv
// Shared encodings for the step recorder: mode values, FSM states and helpers.
package seq_recorder_pkg;

    localparam logic [1:0] MODE_LIVE = 2'b00;
    localparam logic [1:0] MODE_REC  = 2'b01;
    localparam logic [1:0] MODE_PLAY = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    typedef enum logic [2:0] {
        S_LIVE,
        S_REC,
        S_PLAY,
        S_DONE,
        S_CLR
    } state_t;

    // Key vectors are zero-extended to 32 bits before the call.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic state_t mode_state(input logic [1:0] m);
        case (m)
            MODE_REC:  return S_REC;
            MODE_PLAY: return S_PLAY;
            MODE_CLR:  return S_CLR;
            default:   return S_LIVE;
        endcase
    endfunction

endpackage

// File: rtl/seq_recorder_if.sv
// Keyboard-side inputs and tone/LED-side outputs of the step recorder.
interface seq_recorder_if #(
    parameter int NUM_KEYS   = 9,
    parameter int NUM_TRACKS = 2,
    parameter int DEPTH      = 9
);
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [NUM_KEYS-1:0] keys;
    logic                step;
    logic [1:0]          mode;
    logic [TW-1:0]       track_sel;
    logic                loop;
    logic [NUM_KEYS-1:0] note_out;
    logic [PW-1:0]       cur_step;
    logic                rec_full;
    logic                play_done;

    modport master (
        output keys, step, mode, track_sel, loop,
        input  note_out, cur_step, rec_full, play_done
    );

    modport slave (
        input  keys, step, mode, track_sel, loop,
        output note_out, cur_step, rec_full, play_done
    );

endinterface

// File: rtl/seq_recorder_track_mem.sv
// One track's step storage: synchronous write, asynchronous read, no reset
// (entries beyond the track length are never read back).
module seq_track_mem #(
    parameter int NUM_KEYS = 9,
    parameter int DEPTH    = 9,
    parameter int AW       = 4
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [NUM_KEYS-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [NUM_KEYS-1:0] rd_data
);

    logic [NUM_KEYS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/seq_recorder.sv
// Multi-track step recorder/player between the keyboard tracker and the tone stage.
// Per-track lengths and the sequencing FSM live here; patterns live in seq_track_mem.
module seq_recorder
    import seq_recorder_pkg::*;
#(
    parameter int NUM_KEYS   = 9,
    parameter int NUM_TRACKS = 2,
    parameter int DEPTH      = 9
) (
    input  logic           clk,
    input  logic           reset,
    seq_recorder_if.slave  bus
);

    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    state_t              state;
    logic [1:0]          mode_q;
    logic [TW-1:0]       sel_q;
    logic [PW-1:0]       len [NUM_TRACKS];
    logic [PW-1:0]       ptr;
    logic [NUM_KEYS-1:0] note_q;
    logic                rec_full_q;
    logic                play_done_q;
    logic [NUM_KEYS-1:0] rd_data [NUM_TRACKS];

    logic                sel_ok;
    logic                changed;
    logic                rec_we;
    logic                at_end;
    logic [PW-1:0]       len_sel;
    logic [NUM_KEYS-1:0] pattern;
    logic [NUM_KEYS-1:0] mem_q;
    logic [AW-1:0]       rd_addr;

    assign sel_ok  = int'(bus.track_sel) < NUM_TRACKS;
    assign changed = (bus.mode != mode_q) || (bus.track_sel != sel_q);
    assign pattern = is_onehot(32'(bus.keys)) ? bus.keys : '0;
    assign len_sel = sel_ok ? len[bus.track_sel] : '0;
    assign at_end  = (ptr == len_sel);
    assign rec_we  = sel_ok && !changed && (state == S_REC) && bus.step
                     && (len_sel != DEPTH_P);
    // At the end of a track the read port already points at step 0 for a loop wrap.
    assign rd_addr = at_end ? '0 : AW'(ptr);
    assign mem_q   = sel_ok ? rd_data[bus.track_sel] : '0;

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
        seq_track_mem #(
            .NUM_KEYS (NUM_KEYS),
            .DEPTH    (DEPTH),
            .AW       (AW)
        ) u_mem (
            .clk     (clk),
            .wr_en   (rec_we && (int'(bus.track_sel) == t)),
            .wr_addr (AW'(len_sel)),
            .wr_data (pattern),
            .rd_addr (rd_addr),
            .rd_data (rd_data[t])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_LIVE;
            mode_q      <= MODE_LIVE;
            sel_q       <= '0;
            ptr         <= '0;
            note_q      <= '0;
            rec_full_q  <= 1'b0;
            play_done_q <= 1'b0;
            for (int t = 0; t < NUM_TRACKS; t++) begin
                len[t] <= '0;
            end
        end else begin
            mode_q <= bus.mode;
            sel_q  <= bus.track_sel;
            if (!sel_ok) begin
                state       <= S_LIVE;
                ptr         <= '0;
                note_q      <= '0;
                rec_full_q  <= 1'b0;
                play_done_q <= 1'b0;
            end else if (changed) begin
                // Any step arriving with a mode/track change is dropped here.
                state       <= mode_state(bus.mode);
                ptr         <= '0;
                note_q      <= '0;
                rec_full_q  <= 1'b0;
                play_done_q <= 1'b0;
                case (bus.mode)
                    MODE_LIVE: note_q <= pattern;
                    MODE_REC:  len[bus.track_sel] <= '0;
                    MODE_CLR: begin
                        for (int t = 0; t < NUM_TRACKS; t++) begin
                            len[t] <= '0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    S_LIVE: note_q <= pattern;
                    S_REC: begin
                        if (rec_we) begin
                            len[bus.track_sel] <= len_sel + 1'b1;
                            ptr                <= len_sel + 1'b1;
                            note_q             <= pattern;
                            rec_full_q         <= (len_sel + 1'b1) == DEPTH_P;
                        end
                    end
                    S_PLAY: begin
                        if (bus.step) begin
                            if (!at_end) begin
                                note_q <= mem_q;
                                ptr    <= ptr + 1'b1;
                            end else if (bus.loop && (len_sel != '0)) begin
                                note_q <= mem_q;
                                ptr    <= PW'(1);
                            end else begin
                                state       <= S_DONE;
                                note_q      <= '0;
                                play_done_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        note_q      <= '0;
                        play_done_q <= 1'b1;
                    end
                    S_CLR: begin
                        note_q <= '0;
                        for (int t = 0; t < NUM_TRACKS; t++) begin
                            len[t] <= '0;
                        end
                    end
                    default: state <= S_LIVE;
                endcase
            end
        end
    end

    assign bus.note_out  = note_q;
    assign bus.cur_step  = ptr;
    assign bus.rec_full  = rec_full_q;
    assign bus.play_done = play_done_q;

endmodule

// File: tb/tb_seq_recorder.sv
// Bench for seq_recorder: per-cycle comparison against a track-list model plus
// directed scenarios with hand-computed expectations.
module tb_seq_recorder;

    localparam int NK = 9;
    localparam int NT = 2;
    localparam int D  = 9;

    localparam int P_LIVE = 0;
    localparam int P_REC  = 1;
    localparam int P_PLAY = 2;
    localparam int P_DONE = 3;
    localparam int P_CLR  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_recorder_if #(.NUM_KEYS(NK), .NUM_TRACKS(NT), .DEPTH(D)) bus ();

    seq_recorder #(.NUM_KEYS(NK), .NUM_TRACKS(NT), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: each track is a list of recorded patterns with a length; playback walks it.
    logic [NK-1:0] m_trk [NT][D];
    int            m_len [NT];
    int            m_pos;
    int            m_phase;
    logic [NK-1:0] m_note;
    logic          m_full;
    logic          m_done;
    logic [1:0]    m_mode_q;
    int            m_sel_q;
    int            m_sel;
    logic [NK-1:0] m_pat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) m_len[t] = 0;
            m_pos = 0; m_phase = P_LIVE; m_note = '0; m_full = 0; m_done = 0;
            m_mode_q = 2'b00; m_sel_q = 0;
        end else begin
            m_sel = int'(bus.track_sel);
            m_pat = ($countones(bus.keys) == 1) ? bus.keys : '0;
            if (m_sel >= NT) begin
                m_phase = P_LIVE; m_pos = 0; m_note = '0; m_full = 0; m_done = 0;
            end else if (bus.mode != m_mode_q || m_sel != m_sel_q) begin
                m_pos = 0; m_note = '0; m_full = 0; m_done = 0;
                case (bus.mode)
                    2'b00: begin m_phase = P_LIVE; m_note = m_pat; end
                    2'b01: begin m_phase = P_REC; m_len[m_sel] = 0; end
                    2'b10: m_phase = P_PLAY;
                    default: begin
                        m_phase = P_CLR;
                        for (int t = 0; t < NT; t++) m_len[t] = 0;
                    end
                endcase
            end else begin
                case (m_phase)
                    P_LIVE: m_note = m_pat;
                    P_REC: if (bus.step && m_len[m_sel] < D) begin
                        m_trk[m_sel][m_len[m_sel]] = m_pat;
                        m_len[m_sel] = m_len[m_sel] + 1;
                        m_pos  = m_len[m_sel];
                        m_note = m_pat;
                        m_full = (m_len[m_sel] == D);
                    end
                    P_PLAY: if (bus.step) begin
                        if (m_pos < m_len[m_sel]) begin
                            m_note = m_trk[m_sel][m_pos];
                            m_pos  = m_pos + 1;
                        end else if (bus.loop && m_len[m_sel] > 0) begin
                            m_note = m_trk[m_sel][0];
                            m_pos  = 1;
                        end else begin
                            m_phase = P_DONE; m_note = '0; m_done = 1;
                        end
                    end
                    P_DONE: begin m_note = '0; m_done = 1; end
                    default: begin
                        m_note = '0;
                        for (int t = 0; t < NT; t++) m_len[t] = 0;
                    end
                endcase
            end
            m_mode_q = bus.mode;
            m_sel_q  = m_sel;
        end
    end

    always @(negedge clk) begin
        check("note_out", 32'(bus.note_out), 32'(m_note));
        check("cur_step", 32'(bus.cur_step), 32'(m_pos));
        check("rec_full", 32'(bus.rec_full), 32'(m_full));
        check("play_done", 32'(bus.play_done), 32'(m_done));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m, input int s);
        bus.mode      = m;
        bus.track_sel = 1'(s);
        cyc();
    endtask

    task automatic do_step(input logic [NK-1:0] k);
        bus.keys = k;
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
    endtask

    logic [NK-1:0] p1_note [5] = '{9'b100000000, 9'b010000000, 9'b000000000, 9'b000000001, 9'b000000000};
    logic          p1_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int            p1_cur  [5] = '{1, 2, 3, 4, 4};
    logic [NK-1:0] lp_note [7] = '{9'b000000100, 9'b000001000, 9'b000100000,
                                   9'b000000100, 9'b000001000, 9'b000100000, 9'b000000100};
    int            lp_cur  [7] = '{1, 2, 3, 1, 2, 3, 1};

    initial begin
        bus.keys = '0; bus.step = 1'b0; bus.mode = 2'b00; bus.track_sel = '0; bus.loop = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset note_out", 32'(bus.note_out), 32'h0);
        check("reset cur_step", 32'(bus.cur_step), 32'h0);
        check("reset flags", {30'd0, bus.rec_full, bus.play_done}, 32'h0);
        reset = 1'b0;

        // live pass-through
        bus.keys = 9'b000010000; cyc();
        check("live onehot", 32'(bus.note_out), 32'h010);
        bus.keys = 9'b000010001; cyc();
        check("live multi", 32'(bus.note_out), 32'h0);
        bus.keys = 9'b001000000; bus.step = 1'b1; cyc(); bus.step = 1'b0;
        check("live step ignored", 32'(bus.cur_step), 32'h0);

        // record track 0: q, w, rest, o
        set_mode(2'b01, 0);
        do_step(9'b100000000);
        check("rec echo q", 32'(bus.note_out), 32'h100);
        do_step(9'b010000000);
        do_step(9'b110000000);
        check("rec echo rest", 32'(bus.note_out), 32'h0);
        do_step(9'b000000001);
        check("rec cur_step 4", 32'(bus.cur_step), 32'd4);

        // single-shot playback of track 0
        bus.loop = 1'b0;
        set_mode(2'b10, 0);
        check("play entry note", 32'(bus.note_out), 32'h0);
        for (int i = 0; i < 5; i++) begin
            do_step(9'b000000000);
            check("play1 note", 32'(bus.note_out), 32'(p1_note[i]));
            check("play1 done", 32'(bus.play_done), 32'(p1_done[i]));
            check("play1 cur", 32'(bus.cur_step), 32'(p1_cur[i]));
        end
        cyc();
        check("done held", 32'(bus.play_done), 32'h1);

        // fill track 1 past its depth
        set_mode(2'b01, 1);
        for (int i = 0; i < 11; i++) begin
            do_step(9'(1 << (i % 9)));
            check("rec_full", 32'(bus.rec_full), (i >= 8) ? 32'h1 : 32'h0);
        end
        check("full cur_step", 32'(bus.cur_step), 32'd9);
        check("full note held", 32'(bus.note_out), 32'h100);

        // track 0 untouched
        set_mode(2'b10, 0);
        do_step(9'b0);
        check("trk0 after trk1 rec", 32'(bus.note_out), 32'h100);
        do_step(9'b0);
        check("trk0 step2", 32'(bus.note_out), 32'h080);

        // loop playback of a 3-step track
        set_mode(2'b01, 0);
        do_step(9'b000000100);
        do_step(9'b000001000);
        do_step(9'b000100000);
        bus.loop = 1'b1;
        set_mode(2'b10, 0);
        for (int i = 0; i < 7; i++) begin
            do_step(9'b0);
            check("loop note", 32'(bus.note_out), 32'(lp_note[i]));
            check("loop cur", 32'(bus.cur_step), 32'(lp_cur[i]));
        end

        // clear-all then play
        set_mode(2'b11, 0);
        cyc();
        set_mode(2'b10, 1);
        do_step(9'b0);
        check("cleared trk1 done", 32'(bus.play_done), 32'h1);
        check("cleared trk1 note", 32'(bus.note_out), 32'h0);
        set_mode(2'b10, 0);
        do_step(9'b0);
        check("cleared trk0 done", 32'(bus.play_done), 32'h1);

        // reset mid-record
        set_mode(2'b01, 0);
        repeat (4) do_step(9'b100000000);
        #2 reset = 1'b1;
        #1;
        check("async reset note", 32'(bus.note_out), 32'h0);
        check("async reset cur", 32'(bus.cur_step), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();
        bus.loop = 1'b0;
        set_mode(2'b10, 0);
        do_step(9'b0);
        check("post reset done", 32'(bus.play_done), 32'h1);

        // step coincident with record->play change is dropped
        set_mode(2'b01, 0);
        do_step(9'b000000010);
        do_step(9'b000000100);
        bus.mode = 2'b10; bus.keys = 9'b001000000; bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        check("coinc note", 32'(bus.note_out), 32'h0);
        check("coinc cur", 32'(bus.cur_step), 32'h0);
        do_step(9'b0);
        check("coinc first play", 32'(bus.note_out), 32'h002);
        do_step(9'b0);
        check("coinc second play", 32'(bus.note_out), 32'h004);
        do_step(9'b0);
        check("coinc len kept", 32'(bus.play_done), 32'h1);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
